capture_line_writer: RTL
========================

Name: capture_line_writer

Overview:
- Write side of the 800-entry pixel sample line buffer; the display-side register reads this buffer one word per pixel.
- Synchronises the four analyzer channels and waits for a trigger edge on a selected channel.
- After the trigger, writes DEPTH prescaled sample words into the buffer, then holds the frame until the display side acknowledges it.

Parameters:
- DEPTH, 800, samples per captured line (one per display pixel).
- ADDR_W, 10, write address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 9, buffer word width; fixed layout, see Behaviour.
- PRESC_W, 8, prescaler width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_in  in  4  raw asynchronous analyzer channels.
- arm  in  1  one-cycle request to arm the capture (accepted only in IDLE).
- abort  in  1  returns to IDLE from any state.
- continuous  in  1  re-arm automatically after frame_ack.
- trig_sel  in  2  channel index used as trigger source.
- trig_rise  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- prescale  in  PRESC_W  write one sample every prescale+1 clocks.
- frame_ack  in  1  display side has consumed the completed line.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  DATA_W  buffer write word.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops 0, counters 0.
- Reset is asserted asynchronously and released synchronously by the system; a reset mid-capture discards the partial line.
- Input synchroniser: ch_in passes through 2 flops to give sync; a third flop gives prev. The trigger compares sync and prev of channel trig_sel.
- Latency: ch_in change -> visible in sync after 2 clocks.
- States:
  - IDLE: arm=1 -> ARMED.
  - ARMED: trigger edge at cycle T -> CAPTURE at T+1. Edge is sync=1 & prev=0 when trig_rise=1, or sync=0 & prev=1 when trig_rise=0. Edge checks run every clock and are not prescaled.
  - CAPTURE: write DEPTH samples (details below), then -> DONE.
  - DONE: frame_ack=1 -> ARMED if continuous=1, else IDLE.
- CAPTURE writes:
  - First write at cycle T+1: wr_en=1, wr_addr=0, data taken from sync at T.
  - Each later write samples sync on the cycle before its strobe; writes occur every prescale+1 clocks.
  - The prescale counter loads 0 on CAPTURE entry; prescale is sampled once at entry, so changes during CAPTURE are ignored.
  - wr_en is a single-cycle pulse per sample; wr_addr increments by 1 per write.
  - The write at address DEPTH-1 is the last. The next cycle enters DONE with wr_en=0 and wr_addr held at DEPTH-1.
- wr_data layout:
  - bit 8: trigger marker, 1 only at address 0.
  - bits 7:4: transition flags, channel sample XOR the previously written sample. At address 0 the comparison is against prev at T.
  - bits 3:0: channel sample.
- Outputs are registered; wr_data and wr_addr are valid only while wr_en=1.
- busy=1 in ARMED/CAPTURE; done=1 exactly while in DONE.
- Precedence:
  - abort > frame_ack/trigger > arm.
  - abort during CAPTURE: wr_en=0 from the next cycle; no further writes.
  - arm outside IDLE is ignored.
  - frame_ack outside DONE is ignored.
- Trigger present on the same cycle as entering ARMED is not seen; detection starts the cycle after entry.
- prescale=0 gives DEPTH writes on DEPTH consecutive cycles.

Decomposition:
- Shared package (la_pkg): state enum {IDLE, ARMED, CAPTURE, DONE}, LINE_DEPTH=800, PIX_ADDR_W=10, PIX_DATA_W=9, and bit-field positions TRIG_BIT=8, XOR_LSB=4, CH_LSB=0.
- One natural sub-module, la_input_sync: 4-bit 2-flop synchroniser plus prev register and edge detect, with asynchronous active-low reset.

Test Plan:
- Reset mid-capture: assert rst_n=0 at write 300 -> all outputs 0 immediately; after release, state IDLE with no writes.
- Basic capture: prescale=0, trig_sel=2, trig_rise=1, ch_in toggles 0x0->0x4 -> wr_en high 800 consecutive cycles, addresses 0..799. Address 0 data = 9'h144; done rises the cycle after address 799.
- Prescale: prescale=3, falling trigger on ch0 -> writes 4 clocks apart. Write 799 lands 3196 clocks after the first write; wr_en duty is 1 in 4.
- Frame handshake: in DONE, with continuous=1, pulse frame_ack -> busy=1 and done=0 next cycle. A second trigger rewrites address 0 with bit8=1. With continuous=0 -> IDLE, busy=0.
- Abort precedence: abort and frame_ack in the same cycle -> IDLE. Abort at address 123 -> no wr_en afterwards, done never asserts.
- No trigger: arm with the selected channel held constant for 10000 cycles -> wr_en stays 0, busy=1. Edges on non-selected channels are ignored.

Source files
------------

// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared states, sizes and buffer word layout for the capture line writer
package la_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int LINE_DEPTH = 800;
    localparam int PIX_ADDR_W = 10;
    localparam int PIX_DATA_W = 9;
    localparam int NUM_CH     = 4;

    localparam int TRIG_BIT   = 8;
    localparam int XOR_LSB    = 4;
    localparam int CH_LSB     = 0;

    // Assemble one buffer word: trigger marker, per-channel transition flags, raw sample.
    function automatic logic [PIX_DATA_W-1:0] pack_word(
        input logic              marker,
        input logic [NUM_CH-1:0] flags,
        input logic [NUM_CH-1:0] sample
    );
        logic [PIX_DATA_W-1:0] w;
        w                    = '0;
        w[TRIG_BIT]          = marker;
        w[XOR_LSB +: NUM_CH] = flags;
        w[CH_LSB +: NUM_CH]  = sample;
        return w;
    endfunction
endpackage

// File: rtl/la_input_sync.sv
// rtl/la_input_sync.sv - two-flop channel synchroniser with history flop and trigger edge detect
module la_input_sync
    import la_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_in,
    input  logic [1:0]        trig_sel,
    input  logic              trig_rise,
    output logic [NUM_CH-1:0] sync,
    output logic [NUM_CH-1:0] prev,
    output logic              edge_det
);
    logic [NUM_CH-1:0] meta;

    // Metastability chain plus one extra stage so the edge detector sees consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= ch_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign edge_det = trig_rise ? ( sync[trig_sel] & ~prev[trig_sel])
                                : (~sync[trig_sel] &  prev[trig_sel]);
endmodule

// File: rtl/capture_line_writer.sv
// rtl/capture_line_writer.sv - triggered capture of one prescaled sample line into the pixel buffer
module capture_line_writer
    import la_pkg::*;
#(
    parameter int DEPTH   = LINE_DEPTH,
    parameter int ADDR_W  = PIX_ADDR_W,
    parameter int DATA_W  = PIX_DATA_W,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         ch_in,
    input  logic               arm,
    input  logic               abort,
    input  logic               continuous,
    input  logic [1:0]         trig_sel,
    input  logic               trig_rise,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               frame_ack,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               busy,
    output logic               done
);
    state_t             state_q;
    state_t             state_d;
    logic [3:0]         sync;
    logic [3:0]         prev;
    logic               edge_det;
    logic [3:0]         last_sample;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_val;
    logic               trig_hit;
    logic               last_write;

    la_input_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_in     (ch_in),
        .trig_sel  (trig_sel),
        .trig_rise (trig_rise),
        .sync      (sync),
        .prev      (prev),
        .edge_det  (edge_det)
    );

    // Edges only count once ARMED is the registered state, so an edge on the arming cycle is missed.
    assign trig_hit   = (state_q == ARMED) && edge_det;
    assign last_write = (state_q == CAPTURE) && wr_en && (wr_addr == ADDR_W'(DEPTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other request.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (arm)        state_d = ARMED;
                ARMED:   if (trig_hit)   state_d = CAPTURE;
                CAPTURE: if (last_write) state_d = DONE;
                DONE:    if (frame_ack)  state_d = continuous ? ARMED : IDLE;
                default:                 state_d = IDLE;
            endcase
        end
    end

    // Write datapath: first word on trigger, then one word each time the prescaler wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            last_sample <= '0;
            presc_cnt   <= '0;
            presc_val   <= '0;
        end else begin
            wr_en <= 1'b0;
            if (!abort) begin
                if (trig_hit) begin
                    wr_en       <= 1'b1;
                    wr_addr     <= '0;
                    wr_data     <= DATA_W'(pack_word(1'b1, sync ^ prev, sync));
                    last_sample <= sync;
                    presc_cnt   <= '0;
                    presc_val   <= prescale;
                end else if (state_q == CAPTURE && !last_write) begin
                    if (presc_cnt == presc_val) begin
                        presc_cnt   <= '0;
                        wr_en       <= 1'b1;
                        wr_addr     <= wr_addr + ADDR_W'(1);
                        wr_data     <= DATA_W'(pack_word(1'b0, sync ^ last_sample, sync));
                        last_sample <= sync;
                    end else begin
                        presc_cnt <= presc_cnt + PRESC_W'(1);
                    end
                end
            end
        end
    end

    assign busy = (state_q == ARMED) || (state_q == CAPTURE);
    assign done = (state_q == DONE);
endmodule
